// File: rtl/selector_n1_reg.sv
// selector_n1_reg
// Registered N:1 selector driven by a one-hot choice. A request whose choice
// is not exactly one-hot is rejected and reported. Rejections raise a
// one-cycle pulse, set a sticky flag and bump a saturating 8-bit counter.
//
// Optional feature macro: SELECTOR_HOLD_ON_ERR_EN
//   undefined : a rejected request clears result to zero
//   defined   : a rejected request leaves result unchanged
module selector_n1_reg #(
    parameter int WIDTH = 3,
    parameter int NUM   = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM*WIDTH-1:0]   options,
    input  logic [NUM-1:0]         choice,
    input  logic                   sel_valid,
    input  logic                   err_clr,
    output logic [WIDTH-1:0]       result,
    output logic                   result_valid,
    output logic                   choice_err,
    output logic                   err_sticky,
    output logic [7:0]             err_cnt
);

    localparam int IDX_W = (NUM > 1) ? $clog2(NUM) : 1;

    logic             choice_legal;
    logic             req_ok;
    logic             req_bad;
    logic [IDX_W-1:0] sel_idx;
    logic [WIDTH-1:0] opt_arr [NUM];
    logic [WIDTH-1:0] opt_sel;

    // One-hot test: non-zero, and clearing the lowest set bit leaves nothing.
    assign choice_legal = (choice != '0) && ((choice & (choice - NUM'(1))) == '0);
    assign req_ok       = sel_valid && choice_legal;
    assign req_bad      = sel_valid && !choice_legal;

    // Unpack the flat option bus into one entry per option.
    always_comb begin
        for (int k = 0; k < NUM; k++) begin
            opt_arr[k] = options[k*WIDTH +: WIDTH];
        end
    end

    // One-hot to index by OR-ing the indices of set bits. Multi-hot values
    // are rejected before reaching the data path, so no priority is needed.
    always_comb begin
        sel_idx = '0;
        for (int k = 0; k < NUM; k++) begin
            if (choice[k]) begin
                sel_idx = sel_idx | IDX_W'(k);
            end
        end
    end

    // Option mux indexed by the encoded choice.
    always_comb begin
        opt_sel = '0;
        for (int k = 0; k < NUM; k++) begin
            if (sel_idx == IDX_W'(k)) begin
                opt_sel = opt_arr[k];
            end
        end
    end

    // Data path: load result on a legal request; flags are single-cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            result       <= '0;
            result_valid <= 1'b0;
            choice_err   <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            choice_err   <= 1'b0;
            if (req_ok) begin
                result       <= opt_sel;
                result_valid <= 1'b1;
            end else if (req_bad) begin
`ifdef SELECTOR_HOLD_ON_ERR_EN
                result       <= result;
`else
                result       <= '0;
`endif
                choice_err   <= 1'b1;
            end
        end
    end

    // Error bookkeeping: a new error outranks a simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_sticky <= 1'b0;
            err_cnt    <= 8'd0;
        end else if (req_bad) begin
            err_sticky <= 1'b1;
            if (err_clr) begin
                err_cnt <= 8'd1;
            end else if (err_cnt != 8'hFF) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end else if (err_clr) begin
            err_sticky <= 1'b0;
            err_cnt    <= 8'd0;
        end
    end

endmodule

// File: tb/tb_selector_n1_reg.sv
// Bench for selector_n1_reg: directed scenarios with literal expectations,
// then randomized traffic, all compared every cycle against a reference model.
module tb_selector_n1_reg;

    localparam int W = 3;
    localparam int N = 5;
    localparam logic [N*W-1:0] OPTS = 15'b101_100_011_010_001;

    logic           clk;
    logic           rst;
    logic [N*W-1:0] options;
    logic [N-1:0]   choice;
    logic           sel_valid;
    logic           err_clr;
    logic [W-1:0]   result;
    logic           result_valid;
    logic           choice_err;
    logic           err_sticky;
    logic [7:0]     err_cnt;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [W-1:0] m_res;
    logic         m_valid;
    logic         m_err;
    logic         m_sticky;
    int           m_cnt;
    logic         chk_en;

    selector_n1_reg #(.WIDTH(W), .NUM(N)) dut (
        .clk          (clk),
        .rst          (rst),
        .options      (options),
        .choice       (choice),
        .sel_valid    (sel_valid),
        .err_clr      (err_clr),
        .result       (result),
        .result_valid (result_valid),
        .choice_err   (choice_err),
        .err_sticky   (err_sticky),
        .err_cnt      (err_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] pick(input logic [N*W-1:0] o, input logic [N-1:0] c);
        for (int k = 0; k < N; k++) begin
            if (c == N'(1 << k)) return o[k*W +: W];
        end
        return '0;
    endfunction

    // Reference model: outputs derived from the request rules.
    always @(posedge clk) begin
        if (rst) begin
            m_res    <= '0;
            m_valid  <= 1'b0;
            m_err    <= 1'b0;
            m_sticky <= 1'b0;
            m_cnt    <= 0;
            chk_en   <= 1'b1;
        end else if (sel_valid && $countones(choice) == 1) begin
            m_res   <= pick(options, choice);
            m_valid <= 1'b1;
            m_err   <= 1'b0;
            if (err_clr) begin
                m_sticky <= 1'b0;
                m_cnt    <= 0;
            end
        end else if (sel_valid) begin
`ifndef SELECTOR_HOLD_ON_ERR_EN
            m_res    <= '0;
`endif
            m_valid  <= 1'b0;
            m_err    <= 1'b1;
            m_sticky <= 1'b1;
            m_cnt    <= err_clr ? 1 : ((m_cnt + 1 > 255) ? 255 : m_cnt + 1);
        end else begin
            m_valid <= 1'b0;
            m_err   <= 1'b0;
            if (err_clr) begin
                m_sticky <= 1'b0;
                m_cnt    <= 0;
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("result",       int'(result),       int'(m_res));
            chk("result_valid", int'(result_valid), int'(m_valid));
            chk("choice_err",   int'(choice_err),   int'(m_err));
            chk("err_sticky",   int'(err_sticky),   int'(m_sticky));
            chk("err_cnt",      int'(err_cnt),      m_cnt);
        end
    end

    task automatic drive(input bit r, input bit sv, input logic [N-1:0] ch, input bit clr);
        rst       = r;
        sel_valid = sv;
        choice    = ch;
        err_clr   = clr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        chk_en    = 1'b0;
        rst       = 1'b1;
        options   = OPTS;
        choice    = '0;
        sel_valid = 1'b0;
        err_clr   = 1'b0;

        drive(1, 1, 5'b10000, 0);
        drive(1, 0, 5'b00000, 0);
        chk("reset_result", int'(result), 0);
        chk("reset_valid",  int'(result_valid), 0);
        chk("reset_cnt",    int'(err_cnt), 0);

        // Sweep of every legal choice on consecutive cycles.
        for (int k = 0; k < N; k++) begin
            drive(0, 1, N'(1 << k), 0);
            chk("sweep_result", int'(result), k + 1);
            chk("sweep_valid",  int'(result_valid), 1);
        end

        // Legal then multi-hot.
        drive(0, 1, 5'b00100, 0);
        chk("legal_result", int'(result), 3);
        drive(0, 1, 5'b00110, 0);
`ifdef SELECTOR_HOLD_ON_ERR_EN
        chk("multihot_result", int'(result), 3);
`else
        chk("multihot_result", int'(result), 0);
`endif
        chk("multihot_valid",  int'(result_valid), 0);
        chk("multihot_err",    int'(choice_err), 1);
        chk("multihot_sticky", int'(err_sticky), 1);
        chk("multihot_cnt",    int'(err_cnt), 1);

        // Hold with sel_valid low.
        drive(0, 1, 5'b01000, 0);
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 5'b11111, 0);
            chk("idle_result", int'(result), 4);
            chk("idle_valid",  int'(result_valid), 0);
            chk("idle_err",    int'(choice_err), 0);
        end

        // Clear alone, then clear colliding with an error.
        drive(0, 0, 5'b00000, 1);
        chk("clr_cnt",    int'(err_cnt), 0);
        chk("clr_sticky", int'(err_sticky), 0);
        drive(0, 1, 5'b00000, 1);
        chk("clr_err_cnt",    int'(err_cnt), 1);
        chk("clr_err_sticky", int'(err_sticky), 1);

        // Saturation of the error counter.
        drive(0, 0, 5'b00000, 1);
        for (int i = 0; i < 300; i++) begin
            drive(0, 1, 5'b00000, 0);
            if (i == 253) chk("cnt_254", int'(err_cnt), 254);
            if (i == 254) chk("cnt_255", int'(err_cnt), 255);
        end
        chk("cnt_sat",    int'(err_cnt), 255);
        chk("sat_sticky", int'(err_sticky), 1);

        // Reset colliding with a request, then a request on the release edge.
        drive(0, 1, 5'b00001, 0);
        chk("pre_rst_result", int'(result), 1);
        drive(1, 1, 5'b10000, 0);
        chk("rst_req_result", int'(result), 0);
        chk("rst_req_valid",  int'(result_valid), 0);
        chk("rst_req_cnt",    int'(err_cnt), 0);
        chk("rst_req_sticky", int'(err_sticky), 0);
        drive(0, 1, 5'b10000, 0);
        chk("release_result", int'(result), 5);
        chk("release_valid",  int'(result_valid), 1);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            logic [N-1:0] ch;
            options = N*W'($urandom);
            if ($urandom_range(0, 1) == 0) ch = N'(1 << $urandom_range(0, N - 1));
            else                           ch = N'($urandom);
            drive($urandom_range(0, 99) < 2, $urandom_range(0, 9) < 8, ch,
                  $urandom_range(0, 99) < 5);
        end

        drive(0, 0, 5'b00000, 0);
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
